// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, ASCII byte constants, defaults.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB      = 2'd0,
    PULSE    = 2'd1,
    WAIT_RFN = 2'd2
  } state_t;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned EN_CYC_DEF = 2;

  localparam logic [BYTE_W-1:0] ASCII_I = 8'h69;
  localparam logic [BYTE_W-1:0] ASCII_D = 8'h44;
  localparam logic [BYTE_W-1:0] ASCII_O = 8'h4F;
  localparam logic [BYTE_W-1:0] ASCII_M = 8'h4D;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker; a held message lock restricts the grant to its owner.
module uart_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  input  logic             lock,
  input  logic [PW-1:0]    owner,
  output logic [N_REQ-1:0] grant_c,
  output logic [PW-1:0]    idx_c,
  output logic             valid_c
);

  int pos;

  // Scan from the farthest offset down so the requester nearest rr_ptr wins last.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    pos     = 0;
    if (lock) begin
      if (req[owner]) begin
        grant_c[owner] = 1'b1;
        idx_c          = owner;
        valid_c        = 1'b1;
      end
    end else begin
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
        pos = int'(rr_ptr) + i;
        if (pos >= int'(N_REQ)) pos = pos - int'(N_REQ);
        if (req[PW'(pos)]) begin
          grant_c             = '0;
          grant_c[PW'(pos)]   = 1'b1;
          idx_c               = PW'(pos);
          valid_c             = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_Tx serializer between N_REQ byte sources, round-robin with per-message locking.
// Bytes are paced by UART_Tx's ready-for-next pulse, with a watchdog if that pulse never comes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned EN_CYC      = EN_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic                 clk,
  input  logic                 i_nRST,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [8*N_REQ-1:0]   i_data,
  input  logic [N_REQ-1:0]     i_last,
  output logic [N_REQ-1:0]     o_ack,
  output logic [BYTE_W-1:0]    o_data,
  output logic                 o_nTx_EN,
  input  logic                 i_RFN,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int unsigned PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned ECW = $clog2(EN_CYC + 1);
  localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);

  state_t             state, state_n;
  logic [PW-1:0]      rr_ptr, rr_ptr_n;
  logic [PW-1:0]      owner, owner_n;
  logic               lock, lock_n;
  logic               rfn_seen, rfn_seen_n;
  logic [ECW-1:0]     en_cnt, en_cnt_n;
  logic [WDW-1:0]     wd, wd_n;
  logic [N_REQ-1:0]   ack_n;
  logic [BYTE_W-1:0]  data_n;
  logic               ntx_n, busy_n, timeout_n;

  logic [N_REQ-1:0]   pick_grant_c;
  logic [PW-1:0]      pick_idx_c;
  logic               pick_valid_c;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
    if (x == PW'(N_REQ - 1)) return '0;
    return x + PW'(1);
  endfunction

  uart_rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req     (i_req),
    .rr_ptr  (rr_ptr),
    .lock    (lock),
    .owner   (owner),
    .grant_c (pick_grant_c),
    .idx_c   (pick_idx_c),
    .valid_c (pick_valid_c)
  );

  always_ff @(posedge clk or negedge i_nRST) begin
    if (!i_nRST) begin
      state     <= ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      lock      <= 1'b0;
      rfn_seen  <= 1'b0;
      en_cnt    <= '0;
      wd        <= '0;
      o_ack     <= '0;
      o_data    <= '0;
      o_nTx_EN  <= 1'b1;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      owner     <= owner_n;
      lock      <= lock_n;
      rfn_seen  <= rfn_seen_n;
      en_cnt    <= en_cnt_n;
      wd        <= wd_n;
      o_ack     <= ack_n;
      o_data    <= data_n;
      o_nTx_EN  <= ntx_n;
      o_busy    <= busy_n;
      o_timeout <= timeout_n;
    end
  end

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    owner_n    = owner;
    lock_n     = lock;
    rfn_seen_n = rfn_seen;
    en_cnt_n   = en_cnt;
    wd_n       = wd;
    ack_n      = '0;
    data_n     = o_data;
    ntx_n      = o_nTx_EN;
    timeout_n  = 1'b0;

    unique case (state)
      ARB: begin
        if (pick_valid_c) begin
          data_n     = i_data[{pick_idx_c, 3'b000} +: BYTE_W];
          ack_n      = pick_grant_c;
          ntx_n      = 1'b0;
          owner_n    = pick_idx_c;
          lock_n     = ~i_last[pick_idx_c];
          if (i_last[pick_idx_c]) rr_ptr_n = wrap_inc(pick_idx_c);
          en_cnt_n   = '0;
          rfn_seen_n = 1'b0;
          state_n    = PULSE;
        end else if (lock && !i_req[owner]) begin
          // Owner abandoned its message mid-way: free the serializer for the others.
          lock_n   = 1'b0;
          rr_ptr_n = wrap_inc(owner);
        end
      end
      PULSE: begin
        if (i_RFN) rfn_seen_n = 1'b1;
        if (en_cnt == ECW'(EN_CYC - 1)) begin
          ntx_n   = 1'b1;
          wd_n    = '0;
          state_n = WAIT_RFN;
        end else begin
          en_cnt_n = en_cnt + ECW'(1);
        end
      end
      WAIT_RFN: begin
        if (rfn_seen || i_RFN) begin
          state_n = ARB;
        end else if (wd == WDW'(TIMEOUT_CYC - 1)) begin
          timeout_n = 1'b1;
          state_n   = ARB;
        end else begin
          wd_n = wd + WDW'(1);
        end
      end
      default: state_n = ARB;
    endcase

    busy_n = lock_n | (state_n != ARB);
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle table for the basic byte handshake plus multi-cycle scenarios.
module tb_uart_tx_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned TO  = 200;
  localparam int unsigned NV  = 8;

  logic          clk;
  logic          i_nRST;
  logic [N-1:0]  i_req;
  logic [8*N-1:0] i_data;
  logic [N-1:0]  i_last;
  logic [N-1:0]  o_ack;
  logic [7:0]    o_data;
  logic          o_nTx_EN;
  logic          i_RFN;
  logic          o_busy;
  logic          o_timeout;

  int checks = 0;
  int errors = 0;
  bit mon_busy = 0;
  bit busy_low = 0;

  typedef struct {
    logic [N-1:0]   req;
    logic [8*N-1:0] data;
    logic [N-1:0]   last;
    logic           rfn;
    logic [N-1:0]   ack;
    logic [7:0]     odata;
    logic           ntx;
    logic           busy;
    logic           tmo;
  } vec_t;

  vec_t vt [NV];

  uart_tx_arbiter #(.N_REQ(N), .EN_CYC(2), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .i_nRST    (i_nRST),
    .i_req     (i_req),
    .i_data    (i_data),
    .i_last    (i_last),
    .o_ack     (o_ack),
    .o_data    (o_data),
    .o_nTx_EN  (o_nTx_EN),
    .i_RFN     (i_RFN),
    .o_busy    (o_busy),
    .o_timeout (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (mon_busy && !o_busy) busy_low = 1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_ack(input string name, input logic [N-1:0] ea, input logic [7:0] ed, input int bound);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (o_ack == '0 && n < bound);
    if (o_ack == '0) begin
      checks++;
      errors++;
      $display("FAIL %s no ack within %0d cycles want %0h", name, bound, ea);
    end else begin
      check({name, ".ack"}, 32'(o_ack), 32'(ea));
      check({name, ".data"}, 32'(o_data), 32'(ed));
    end
  endtask

  task automatic rfn_after(input int n);
    repeat (n) tick();
    i_RFN = 1'b1;
    tick();
    i_RFN = 1'b0;
  endtask

  task automatic do_reset();
    i_nRST = 1'b0;
    i_req  = '0;
    i_data = '0;
    i_last = '0;
    i_RFN  = 1'b0;
    tick();
    tick();
    i_nRST = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    // Single byte handshake: capture, 2-cycle enable, wait for RFN, next capture.
    vt[0] = '{4'b0001, 32'h44, 4'b0001, 1'b0, 4'b0001, 8'h44, 1'b0, 1'b1, 1'b0};
    vt[1] = '{4'b0000, 32'h44, 4'b0001, 1'b0, 4'b0000, 8'h44, 1'b0, 1'b1, 1'b0};
    vt[2] = '{4'b0000, 32'h44, 4'b0001, 1'b0, 4'b0000, 8'h44, 1'b1, 1'b1, 1'b0};
    vt[3] = '{4'b0001, 32'h44, 4'b0001, 1'b0, 4'b0000, 8'h44, 1'b1, 1'b1, 1'b0};
    vt[4] = '{4'b0001, 32'h44, 4'b0001, 1'b0, 4'b0000, 8'h44, 1'b1, 1'b1, 1'b0};
    vt[5] = '{4'b0001, 32'h44, 4'b0001, 1'b1, 4'b0000, 8'h44, 1'b1, 1'b0, 1'b0};
    vt[6] = '{4'b0001, 32'h44, 4'b0001, 1'b0, 4'b0001, 8'h44, 1'b0, 1'b1, 1'b0};
    vt[7] = '{4'b0000, 32'h44, 4'b0001, 1'b0, 4'b0000, 8'h44, 1'b0, 1'b1, 1'b0};

    i_nRST = 1'b0;
    i_req  = '0;
    i_data = '0;
    i_last = '0;
    i_RFN  = 1'b0;
    tick();
    check("rst.ack", 32'(o_ack), 32'h0);
    check("rst.data", 32'(o_data), 32'h0);
    check("rst.ntx", 32'(o_nTx_EN), 32'h1);
    check("rst.busy", 32'(o_busy), 32'h0);
    check("rst.tmo", 32'(o_timeout), 32'h0);
    tick();
    i_nRST = 1'b1;

    for (int v = 0; v < int'(NV); v++) begin
      i_req  = vt[v].req;
      i_data = vt[v].data;
      i_last = vt[v].last;
      i_RFN  = vt[v].rfn;
      tick();
      check($sformatf("vec%0d.ack", v), 32'(o_ack), 32'(vt[v].ack));
      check($sformatf("vec%0d.data", v), 32'(o_data), 32'(vt[v].odata));
      check($sformatf("vec%0d.ntx", v), 32'(o_nTx_EN), 32'(vt[v].ntx));
      check($sformatf("vec%0d.busy", v), 32'(o_busy), 32'(vt[v].busy));
      check($sformatf("vec%0d.tmo", v), 32'(o_timeout), 32'(vt[v].tmo));
    end

    // Two single-byte sources alternate under round-robin.
    do_reset();
    i_req  = 4'b0101;
    i_data = {8'h00, 8'h4D, 8'h00, 8'h44};
    i_last = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_ack($sformatf("rr%0d", k), (k % 2 == 1) ? 4'b0100 : 4'b0001,
               (k % 2 == 1) ? 8'h4D : 8'h44, 300);
      rfn_after(100);
    end

    // Locked three-byte message from source 1 ahead of source 3.
    do_reset();
    busy_low = 0;
    i_req  = 4'b1010;
    i_data = {8'h69, 8'h00, 8'h44, 8'h00};
    i_last = 4'b1000;
    wait_ack("msg.D", 4'b0010, 8'h44, 5);
    mon_busy = 1;
    i_data[15:8] = 8'h4F;
    rfn_after(5);
    wait_ack("msg.O", 4'b0010, 8'h4F, 5);
    i_data[15:8] = 8'h4D;
    i_last[1] = 1'b1;
    rfn_after(5);
    wait_ack("msg.M", 4'b0010, 8'h4D, 5);
    mon_busy = 0;
    i_req[1] = 1'b0;
    check("msg.busy_held", 32'(busy_low), 32'h0);
    rfn_after(5);
    wait_ack("msg.i", 4'b1000, 8'h69, 5);

    // Lock overrides rotation; owner drop releases lock and wraps rr_ptr to 0.
    do_reset();
    i_req  = 4'b1000;
    i_data = {8'h69, 8'h00, 8'h00, 8'h44};
    i_last = 4'b0001;
    wait_ack("lock.i", 4'b1000, 8'h69, 5);
    i_req  = 4'b1001;
    i_data[31:24] = 8'h4F;
    rfn_after(5);
    wait_ack("lock.O", 4'b1000, 8'h4F, 5);
    i_req[3] = 1'b0;
    rfn_after(5);
    tick();
    check("drop.ack", 32'(o_ack), 32'h0);
    check("drop.busy", 32'(o_busy), 32'h0);
    wait_ack("drop.D", 4'b0001, 8'h44, 1);

    // Watchdog fires TO cycles after the enable returns high.
    do_reset();
    i_req  = 4'b0011;
    i_data = {8'h00, 8'h00, 8'h4F, 8'h69};
    i_last = 4'b0011;
    wait_ack("wd.i", 4'b0001, 8'h69, 5);
    i_req[0] = 1'b0;
    n = 0;
    while (o_nTx_EN == 1'b0 && n < 10) begin
      tick();
      n++;
    end
    check("wd.en_len", 32'(n), 32'd2);
    n = 0;
    while (o_timeout == 1'b0 && n < int'(TO) + 50) begin
      tick();
      n++;
    end
    check("wd.delay", 32'(n), 32'(TO));
    check("wd.ack_at_tmo", 32'(o_ack), 32'h0);
    wait_ack("wd.O", 4'b0010, 8'h4F, 1);
    check("wd.tmo_pulse", 32'(o_timeout), 32'h0);

    // Async reset in PULSE, then the pending byte goes without RFN.
    do_reset();
    i_req  = 4'b0100;
    i_data = {8'h00, 8'h4D, 8'h00, 8'h00};
    i_last = 4'b0100;
    wait_ack("rst.M", 4'b0100, 8'h4D, 5);
    i_nRST = 1'b0;
    #1;
    check("midrst.ntx", 32'(o_nTx_EN), 32'h1);
    check("midrst.ack", 32'(o_ack), 32'h0);
    check("midrst.busy", 32'(o_busy), 32'h0);
    tick();
    tick();
    i_nRST = 1'b1;
    wait_ack("postrst.M", 4'b0100, 8'h4D, 1);

    // RFN on the final enable cycle is remembered.
    do_reset();
    i_req  = 4'b0011;
    i_data = {8'h00, 8'h00, 8'h4F, 8'h44};
    i_last = 4'b0011;
    wait_ack("early.D", 4'b0001, 8'h44, 5);
    i_req[0] = 1'b0;
    tick();
    i_RFN = 1'b1;
    tick();
    i_RFN = 1'b0;
    check("early.ntx", 32'(o_nTx_EN), 32'h1);
    tick();
    check("early.tmo", 32'(o_timeout), 32'h0);
    check("early.ack0", 32'(o_ack), 32'h0);
    wait_ack("early.O", 4'b0010, 8'h4F, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
